// File: rtl/siggit_pkg.sv
// Shared constants for the sigma-delta modulator: order codes, integrator growth and full-scale feedback.
// Pure definitions, no latency, no flow control.
package siggit_pkg;

    localparam int ORDER_1   = 1;
    localparam int ORDER_2   = 2;
    localparam int INT_GUARD = 4;

    function automatic int int_width(input int width);
        return width + INT_GUARD;
    endfunction

    // Magnitude of the feedback DAC level: one LSB above the largest positive sample.
    function automatic int full_scale(input int width);
        return 1 << (width - 1);
    endfunction

endpackage

// File: rtl/siggit_chan.sv
// One modulator channel: saturating integrators and 1-bit quantiser; bit registered one clock after update.
// No backpressure; i_en low freezes all state.
module siggit_chan
    import siggit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ORDER = ORDER_2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_x,
    output logic             o_bit
);
    localparam int IW = int_width(WIDTH);
    localparam int SW = IW + 2;
    localparam logic signed [SW-1:0] FS   = SW'(full_scale(WIDTH));
    localparam logic signed [SW-1:0] SMAX = {3'b000, {(IW-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = {3'b111, {(IW-1){1'b0}}};

    logic signed [IW-1:0] r_i1;
    logic signed [IW-1:0] r_i2;
    logic                 r_bit;

    logic signed [SW-1:0] w_x;
    logic signed [SW-1:0] w_fb;
    logic signed [SW-1:0] w_s1;
    logic signed [SW-1:0] w_s2;
    logic signed [IW-1:0] w_i1_nx;
    logic signed [IW-1:0] w_i2_nx;
    logic                 w_bit_nx;

    // Sums are formed two bits wider so overflow is detected before clamping.
    function automatic logic signed [SW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    assign w_x      = {{(SW-WIDTH){i_x[WIDTH-1]}}, i_x};
    assign w_fb     = r_bit ? FS : -FS;
    assign w_s1     = {{2{r_i1[IW-1]}}, r_i1} + w_x - w_fb;
    assign w_i1_nx  = IW'(sat(w_s1));
    assign w_s2     = {{2{r_i2[IW-1]}}, r_i2} + {{2{w_i1_nx[IW-1]}}, w_i1_nx} - w_fb;
    assign w_i2_nx  = IW'(sat(w_s2));
    assign w_bit_nx = (ORDER == ORDER_1) ? ~w_i1_nx[IW-1] : ~w_i2_nx[IW-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_i1  <= '0;
            r_i2  <= '0;
            r_bit <= 1'b0;
        end else if (i_en) begin
            r_i1  <= w_i1_nx;
            r_i2  <= w_i2_nx;
            r_bit <= w_bit_nx;
        end
    end

    assign o_bit = r_bit;

endmodule

// File: rtl/siggit_mc.sv
// Multi-channel sigma-delta modulator: phase counter, one-deep frame holding register, CHANNELS lock-step channels.
// IN_READY drops while a frame is held; a boundary with nothing held reuses the last sample and pulses UNDERRUN.
module siggit_mc
    import siggit_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int ORDER    = ORDER_2,
    parameter int OSR      = 64
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      EN,
    input  logic                      MUTE,
    input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    output logic [CHANNELS-1:0]       BITSTREAM,
    output logic                      SAMPLE_TICK,
    output logic                      UNDERRUN
);
    localparam int FW = CHANNELS * WIDTH;
    localparam int PW = $clog2(OSR);
    localparam logic [PW-1:0] PH_LAST = PW'(OSR - 1);

    logic [PW-1:0] r_phase;
    logic          r_hold_full;
    logic [FW-1:0] r_hold;
    logic [FW-1:0] r_active;

    logic w_boundary;
    logic w_accept;

    assign w_boundary  = EN && (r_phase == PH_LAST);
    assign w_accept    = EN && IN_VALID && !r_hold_full;
    assign IN_READY    = !r_hold_full;
    assign SAMPLE_TICK = w_boundary;
    assign UNDERRUN    = w_boundary && !r_hold_full;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_phase     <= '0;
            r_hold_full <= 1'b0;
            r_hold      <= '0;
            r_active    <= '0;
        end else if (EN) begin
            r_phase <= w_boundary ? '0 : r_phase + PW'(1);
            // Acceptance only happens while empty, so it never collides with the boundary consume.
            if (w_accept) begin
                r_hold      <= IN_DATA;
                r_hold_full <= 1'b1;
            end else if (w_boundary) begin
                r_hold_full <= 1'b0;
            end
            if (w_boundary) begin
                if (MUTE) begin
                    r_active <= '0;
                end else if (r_hold_full) begin
                    r_active <= r_hold;
                end
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        siggit_chan #(
            .WIDTH (WIDTH),
            .ORDER (ORDER)
        ) u_chan (
            .i_clk   (CLK),
            .i_rst_n (RESET_N),
            .i_en    (EN),
            .i_x     (r_active[c*WIDTH +: WIDTH]),
            .o_bit   (BITSTREAM[c])
        );
    end

endmodule

// File: tb/tb_siggit_mc.sv
// Bench for siggit_mc: ORDER 1 and ORDER 2 instances share stimulus; a queue-based sample model is checked every cycle.
// Directed scenarios add literal density, timing and reset expectations.
module tb_siggit_mc;
    localparam int W   = 16;
    localparam int CH  = 2;
    localparam int OSR = 64;
    localparam longint FS   = 32768;
    localparam longint IMAX = 524287;
    localparam longint IMIN = -524288;

    logic          CLK      = 1'b0;
    logic          RESET_N  = 1'b0;
    logic          EN       = 1'b1;
    logic          MUTE     = 1'b0;
    logic          IN_VALID = 1'b0;
    logic [CH*W-1:0] IN_DATA = '0;
    logic          rdy1, rdy2, tick1, tick2, und1, und2;
    logic [CH-1:0] bs1, bs2;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    always #5 CLK = ~CLK;

    siggit_mc #(.WIDTH(W), .CHANNELS(CH), .ORDER(1), .OSR(OSR)) u_dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .MUTE(MUTE), .IN_DATA(IN_DATA),
        .IN_VALID(IN_VALID), .IN_READY(rdy1), .BITSTREAM(bs1),
        .SAMPLE_TICK(tick1), .UNDERRUN(und1));

    siggit_mc #(.WIDTH(W), .CHANNELS(CH), .ORDER(2), .OSR(OSR)) u_dut2 (
        .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .MUTE(MUTE), .IN_DATA(IN_DATA),
        .IN_VALID(IN_VALID), .IN_READY(rdy2), .BITSTREAM(bs2),
        .SAMPLE_TICK(tick2), .UNDERRUN(und2));

    // ---------------- model: index 0 is ORDER 1, index 1 is ORDER 2 ----------------
    longint          m_i1 [2][CH];
    longint          m_i2 [2][CH];
    bit              m_b  [2][CH];
    longint          m_act[CH];
    int              m_ph;
    logic [CH*W-1:0] m_q[$];
    logic [CH*W-1:0] m_f;
    bit              m_bnd, m_acc, m_have;
    longint          m_fb, m_n1, m_n2;

    function automatic longint clampi(input longint v);
        if (v > IMAX) return IMAX;
        if (v < IMIN) return IMIN;
        return v;
    endfunction

    function automatic longint samp(input logic [CH*W-1:0] f, input int c);
        logic signed [W-1:0] s;
        s = f[c*W +: W];
        return longint'(s);
    endfunction

    initial forever begin
        @(posedge CLK or negedge RESET_N);
        if (!RESET_N) begin
            m_ph = 0;
            m_q.delete();
            for (int c = 0; c < CH; c++) begin
                m_act[c] = 0;
                for (int m = 0; m < 2; m++) begin
                    m_i1[m][c] = 0;
                    m_i2[m][c] = 0;
                    m_b[m][c]  = 1'b0;
                end
            end
        end else if (EN) begin
            m_bnd = (m_ph == OSR - 1);
            m_acc = IN_VALID && (m_q.size() == 0);
            for (int m = 0; m < 2; m++) begin
                for (int c = 0; c < CH; c++) begin
                    m_fb = m_b[m][c] ? FS : -FS;
                    m_n1 = clampi(m_i1[m][c] + m_act[c] - m_fb);
                    m_n2 = clampi(m_i2[m][c] + m_n1 - m_fb);
                    m_i1[m][c] = m_n1;
                    m_i2[m][c] = m_n2;
                    m_b[m][c]  = (m == 0) ? (m_n1 >= 0) : (m_n2 >= 0);
                end
            end
            if (m_bnd) begin
                m_have = 1'b0;
                if (m_q.size() > 0) begin
                    m_f    = m_q.pop_front();
                    m_have = 1'b1;
                end
                for (int c = 0; c < CH; c++) begin
                    if (MUTE) m_act[c] = 0;
                    else if (m_have) m_act[c] = samp(m_f, c);
                end
                m_ph = 0;
            end else begin
                m_ph = m_ph + 1;
            end
            if (m_acc) m_q.push_back(IN_DATA);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string nm, input longint v, input longint lo, input longint hi);
        n_cmp++;
        if (v < lo || v > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, v, lo, hi);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        #1;
        if (cmp_on && RESET_N) begin
            chk("bitstream_order1", bs1, {m_b[0][1], m_b[0][0]});
            chk("bitstream_order2", bs2, {m_b[1][1], m_b[1][0]});
            chk("in_ready_order1", rdy1, m_q.size() == 0);
            chk("in_ready_order2", rdy2, m_q.size() == 0);
            chk("sample_tick_order1", tick1, EN && (m_ph == OSR - 1));
            chk("sample_tick_order2", tick2, EN && (m_ph == OSR - 1));
            chk("underrun_order1", und1, EN && (m_ph == OSR - 1) && (m_q.size() == 0));
            chk("underrun_order2", und2, EN && (m_ph == OSR - 1) && (m_q.size() == 0));
        end
    end

    // ---------------- window statistics ----------------
    int o1[CH], o2[CH];
    int rep1, chg, ticks, unders, accs, ival_err, cyc_no, last_tick;
    logic [CH-1:0] p_bs1, p_bs2;
    logic p_rdy;

    task automatic clr_win();
        for (int c = 0; c < CH; c++) begin
            o1[c] = 0;
            o2[c] = 0;
        end
        rep1 = 0; chg = 0; ticks = 0; unders = 0; accs = 0; ival_err = 0;
        cyc_no = 0; last_tick = -1;
        p_bs1 = bs1; p_bs2 = bs2; p_rdy = rdy1;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
            cyc_no++;
            for (int c = 0; c < CH; c++) begin
                o1[c] += int'(bs1[c]);
                o2[c] += int'(bs2[c]);
            end
            if (bs1[0] == p_bs1[0]) rep1++;
            if (bs1 != p_bs1 || bs2 != p_bs2) chg++;
            if (p_rdy && !rdy1) accs++;
            if (und1) unders++;
            if (tick1) begin
                ticks++;
                if (last_tick >= 0 && cyc_no - last_tick != OSR) ival_err++;
                last_tick = cyc_no;
            end
            p_bs1 = bs1; p_bs2 = bs2; p_rdy = rdy1;
        end
    endtask

    task automatic wait_tick(input int limit, output int k);
        k = 0;
        while (k <= limit) begin
            @(posedge CLK);
            #1;
            k++;
            if (tick1) break;
        end
    endtask

    task automatic reset_outputs_chk(input string tag);
        chk({tag, "_bs1"}, bs1, 0);
        chk({tag, "_bs2"}, bs2, 0);
        chk({tag, "_ready"}, rdy1, 1);
        chk({tag, "_tick"}, tick1, 0);
        chk({tag, "_underrun"}, und1, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        reset_outputs_chk("reset");
        @(negedge CLK);
        RESET_N = 1'b1;
        cmp_on  = 1'b1;
    endtask

    task automatic set_frame(input longint c0, input longint c1);
        IN_DATA = {W'(c1), W'(c0)};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    int k;

    initial begin
        // Zero input, ORDER 1 alternates; continuous IN_VALID gives one accept per sample.
        do_reset();
        set_frame(0, 0);
        IN_VALID = 1'b1;
        run_cycles(OSR);
        clr_win();
        run_cycles(256);
        chk_rng("t1_ones_ch0", o1[0], 127, 129);
        chk_rng("t1_ones_ch1", o1[1], 127, 129);
        chk("t1_repeat_bits", rep1, 0);
        chk("t1_accepts", accs, 4);
        chk("t1_underruns", unders, 0);
        chk("t1_ticks", ticks, 4);

        // Half-scale into ORDER 2.
        do_reset();
        set_frame(16384, 16384);
        run_cycles(OSR);
        clr_win();
        run_cycles(1024);
        chk_rng("t2_ones_ch0", o2[0], 764, 772);
        chk_rng("t2_ones_ch1", o2[1], 764, 772);
        chk("t2_accepts", accs, 16);
        chk("t2_underruns", unders, 0);

        // Negative full scale: ORDER 2 output stays low, second integrator clamps.
        do_reset();
        set_frame(-32768, -32768);
        run_cycles(OSR);
        clr_win();
        run_cycles(1024);
        chk_rng("t3_ones_ch0", o2[0], 0, 10);
        chk_rng("t3_ones_ch1", o2[1], 0, 10);
        chk("t3_i2_saturated", $signed(u_dut2.g_chan[0].u_chan.r_i2), IMIN);
        chk("t3_model_i2_saturated", m_i2[1][0], IMIN);

        // Single frame then starvation.
        do_reset();
        set_frame(8192, 8192);
        @(negedge CLK);
        IN_VALID = 1'b0;
        run_cycles(OSR);
        clr_win();
        run_cycles(256);
        chk("t4_ticks", ticks, 4);
        chk("t4_underruns", unders, 4);
        chk("t4_tick_period_errors", ival_err, 0);
        chk_rng("t4_ones_ch0", o1[0], 158, 162);
        chk_rng("t4_ones_ch1", o1[1], 158, 162);

        // Reset with the counter at 30.
        do_reset();
        set_frame(5000, 5000);
        IN_VALID = 1'b1;
        run_cycles(OSR + 30);
        #1;
        RESET_N = 1'b0;
        #1;
        reset_outputs_chk("t5_midreset");
        @(negedge CLK);
        RESET_N = 1'b1;
        wait_tick(100, k);
        chk("t5_clocks_to_tick", k, 63);

        // Mute, then an EN freeze.
        do_reset();
        set_frame(20000, -20000);
        run_cycles(OSR + 30);
        @(negedge CLK);
        MUTE = 1'b1;
        run_cycles(34);
        clr_win();
        run_cycles(128);
        chk_rng("t6_muted_ones_ch0", o1[0], 62, 66);
        chk_rng("t6_muted_ones_ch1", o1[1], 62, 66);
        wait_tick(100, k);
        chk("t6_clocks_to_tick", k, 63);
        run_cycles(11);
        @(negedge CLK);
        EN = 1'b0;
        clr_win();
        run_cycles(10);
        chk("t6_frozen_bit_changes", chg, 0);
        chk("t6_frozen_ticks", ticks, 0);
        chk("t6_frozen_underruns", unders, 0);
        @(negedge CLK);
        EN = 1'b1;
        wait_tick(100, k);
        chk("t6_resume_clocks_to_tick", k, 53);

        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
